// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: SRAM fetch handshake, ID-stage control inputs and the
// IF/ID pipeline register outputs.
interface instr_fetch_if;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] pc_plus1;
   logic        instr_valid;

   modport master (
      input  stall, flush, redirect, redirect_pc, mem_ack, mem_rdata,
      output mem_req, mem_addr, instr, instr_pc, pc_plus1, instr_valid
   );

   modport slave (
      output stall, flush, redirect, redirect_pc, mem_ack, mem_rdata,
      input  mem_req, mem_addr, instr, instr_pc, pc_plus1, instr_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// THINPAD instruction fetch: PC, request/ack SRAM fetch with a one-word
// stall buffer, delayed-branch redirect and the IF/ID pipeline register.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP      = 16'h0800
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   typedef enum logic {FETCH, BUF} state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] buf_word_q;
   logic [15:0] buf_pc_q;
   logic        pend_valid_q;
   logic [15:0] pend_pc_q;
   logic [15:0] instr_q;
   logic [15:0] instr_pc_q;
   logic [15:0] pc_plus1_q;
   logic        instr_valid_q;

   logic [15:0] pc_inc;
   logic        redir_take;
   logic [15:0] accept_pc_d;

   assign pc_inc     = pc_q + 16'd1;
   assign redir_take = bus.redirect & ~bus.stall;

   // A pending redirect was recorded while its delay slot was still in flight,
   // so it wins over anything ID presents now.
   assign accept_pc_d = pend_valid_q ? pend_pc_q
                      : (redir_take ? bus.redirect_pc : pc_inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         buf_word_q    <= NOP;
         buf_pc_q      <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_pc_q     <= RESET_PC;
         instr_q       <= NOP;
         instr_pc_q    <= RESET_PC;
         pc_plus1_q    <= RESET_PC + 16'd1;
         instr_valid_q <= 1'b0;
      end else if (bus.flush) begin
         instr_q       <= NOP;
         instr_valid_q <= 1'b0;
         state_q       <= FETCH;
         pend_valid_q  <= 1'b0;
         // Without a redirect, rewind to the oldest word not yet handed to ID.
         if (bus.redirect)
            pc_q <= bus.redirect_pc;
         else if (state_q == BUF)
            pc_q <= buf_pc_q;
      end else begin
         case (state_q)
            FETCH: begin
               if (bus.mem_ack) begin
                  pc_q         <= accept_pc_d;
                  pend_valid_q <= 1'b0;
                  if (!bus.stall) begin
                     instr_q       <= bus.mem_rdata;
                     instr_pc_q    <= pc_q;
                     pc_plus1_q    <= pc_inc;
                     instr_valid_q <= 1'b1;
                  end else begin
                     buf_word_q <= bus.mem_rdata;
                     buf_pc_q   <= pc_q;
                     state_q    <= BUF;
                  end
               end else begin
                  if (redir_take) begin
                     pend_valid_q <= 1'b1;
                     pend_pc_q    <= bus.redirect_pc;
                  end
                  if (!bus.stall) begin
                     instr_q       <= NOP;
                     instr_valid_q <= 1'b0;
                  end
               end
            end
            BUF: begin
               // pc already points past the buffered word; a redirect replaces it.
               if (redir_take)
                  pc_q <= bus.redirect_pc;
               if (!bus.stall) begin
                  instr_q       <= buf_word_q;
                  instr_pc_q    <= buf_pc_q;
                  pc_plus1_q    <= buf_pc_q + 16'd1;
                  instr_valid_q <= 1'b1;
                  state_q       <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign bus.mem_req     = (state_q == FETCH);
   assign bus.mem_addr    = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.pc_plus1    = pc_plus1_q;
   assign bus.instr_valid = instr_valid_q;

endmodule
